muldiv_unit: RTL and testbench

Iterative multiply/divide/accumulate engine that sits beside the EX stage and owns every HI/LO-producing multi-cycle operation. EX launches an operation with a start strobe, holds the pipeline stalled while `busy_o` is high, and consumes the `{hi, lo}` result on the single-cycle `ready_o` pulse. Operand width and multiplier throughput are parameters. The unit also adds signed/unsigned multiply-accumulate and multiply-subtract, divide-by-zero reporting, and an annul path for flushed instructions.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_divider.sv | 56 +++++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM states and op predicates shared by the muldiv block
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MADDU = 3'd3;
  localparam logic [2:0] OP_MSUB  = 3'd4;
  localparam logic [2:0] OP_MSUBU = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_DIVU  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_ACC,
    ST_FIX,
    ST_DONE
  } state_e;

  // Even op codes are the signed flavours.
  function automatic logic is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op >= OP_MADD) && (op <= OP_MSUBU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return op[2] & ~op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - EX-side launch/result bundle of the muldiv unit
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic               start_i;
  logic [2:0]         op_i;
  logic [WIDTH-1:0]   opa_i;
  logic [WIDTH-1:0]   opb_i;
  logic [2*WIDTH-1:0] acc_i;
  logic               annul_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;
  logic               div0_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, acc_i, annul_i,
    input  busy_o, ready_o, result_o, div0_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, acc_i, annul_i,
    output busy_o, ready_o, result_o, div0_o
  );

endinterface

// File: rtl/muldiv_divider.sv
// rtl/muldiv_divider.sv - restoring radix-2 divider on unsigned magnitudes, one bit per step
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic [WIDTH:0]   shifted, diff;

  // Quotient register doubles as the dividend shift register; diff[WIDTH] is the borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    if (load_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      dvsr_d = divisor_i;
    end else if (step_i) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide engine beside EX
// MADD/MADDU/MSUB/MSUBU and the ACC state exist only when MULDIV_ACC_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam int W  = WIDTH;
  localparam int NM = WIDTH / MUL_STEP;
  localparam int CW = $clog2(WIDTH + 1);

  state_e         state_q, state_d, mul_next;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   amag_q, amag_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic           neg_q, neg_d, rneg_q, rneg_d, div_q, div_d;
  logic [2*W-1:0] result_q, result_d;
  logic           div0_q, div0_d;

  logic                  legal, accept, sa, sb, bzero, dv_step;
  logic [W-1:0]          amag_in, bmag_in, a_orig, quo, rem, q_fix, r_fix;
  logic [W+MUL_STEP-1:0] mul_sum;
  logic [2*W-1:0]        prod_fix;

  assign sa      = is_signed(bus.op_i) & bus.opa_i[W-1];
  assign sb      = is_signed(bus.op_i) & bus.opb_i[W-1];
  assign amag_in = sa ? -bus.opa_i : bus.opa_i;
  assign bmag_in = sb ? -bus.opb_i : bus.opb_i;
  assign accept  = bus.start_i & ~bus.annul_i & legal & (state_q == ST_IDLE);

  // prod_q low half starts as the multiplier magnitude and is shifted out as product bits
  // shift in; during DIV it still holds the divisor magnitude, which gives the zero test.
  assign mul_sum  = {{MUL_STEP{1'b0}}, prod_q[2*W-1:W]}
                  + ({{MUL_STEP{1'b0}}, amag_q} * {{W{1'b0}}, prod_q[MUL_STEP-1:0]});
  assign bzero    = (prod_q[W-1:0] == '0);
  assign a_orig   = rneg_q ? -amag_q : amag_q;
  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = rneg_q ? -rem : rem;

`ifdef MULDIV_ACC_EN
  logic [2*W-1:0] acc_q, acc_res;
  logic           acc_op_q, sub_q;

  assign legal    = 1'b1;
  assign mul_next = acc_op_q ? ST_ACC : ST_FIX;
  assign acc_res  = sub_q ? (acc_q - prod_fix) : (acc_q + prod_fix);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      acc_op_q <= 1'b0;
      sub_q    <= 1'b0;
    end else if (accept) begin
      acc_q    <= bus.acc_i;
      acc_op_q <= is_acc(bus.op_i);
      sub_q    <= is_sub(bus.op_i);
    end
  end
`else
  logic unused_acc;

  assign legal      = ~is_acc(bus.op_i);
  assign mul_next   = ST_FIX;
  assign unused_acc = ^bus.acc_i;
`endif

  muldiv_divider #(.WIDTH(W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .step_i     (dv_step),
    .dividend_i (amag_in),
    .divisor_i  (bmag_in),
    .quo_o      (quo),
    .rem_o      (rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    amag_d   = amag_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div_d    = div_q;
    result_d = result_q;
    div0_d   = div0_q;
    dv_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = is_div(bus.op_i) ? ST_DIV : ST_MUL;
          cnt_d   = '0;
          amag_d  = amag_in;
          prod_d  = {{W{1'b0}}, bmag_in};
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          div_d   = is_div(bus.op_i);
          div0_d  = 1'b0;
        end
      end
      ST_MUL: begin
        prod_d = {mul_sum, prod_q[W-1:MUL_STEP]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(NM - 1)) state_d = mul_next;
      end
      ST_DIV: begin
        if (bzero) begin
          state_d  = ST_DONE;
          result_d = {a_orig, {W{1'b1}}};
          div0_d   = 1'b1;
        end else begin
          dv_step = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_d = ST_FIX;
        end
      end
`ifdef MULDIV_ACC_EN
      ST_ACC: begin
        state_d  = ST_DONE;
        result_d = acc_res;
      end
`endif
      ST_FIX: begin
        state_d  = ST_DONE;
        result_d = div_q ? {r_fix, q_fix} : prod_fix;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The result is already committed once DONE is reached, so annul cannot cancel it there.
    if (bus.annul_i && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      div0_d   = div0_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      amag_q   <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div_q    <= 1'b0;
      result_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      amag_q   <= amag_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div_q    <= div_d;
      result_q <= result_d;
      div0_q   <= div0_d;
    end
  end

  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.ready_o  = (state_q == ST_DONE);
  assign bus.result_o = result_q;
  assign bus.div0_o   = div0_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (W=32/STEP=1 and W=16/STEP=4)
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic        dz;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
    logic [7:0]  lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;
  logic [63:0] last_res = '0;
  int c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_if #(.WIDTH(16)) bus2 ();

  muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  muldiv_unit #(.WIDTH(16), .MUL_STEP(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  vec_t vecs [11] = '{
    '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 8'd34},
    '{OP_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 8'd34},
    '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 8'd34},
    '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 8'd34},
    '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 8'd34},
    '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 64'h00000000_0000000F, 1'b0, 8'd34},
    '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 8'd34},
    '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 1'b0, 8'd34},
    '{OP_DIV,   32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1, 8'd2},
    '{OP_DIV,   32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF, 1'b1, 8'd2},
    '{OP_MULT,  32'd7,        32'd6,        64'h00000000_0000002A, 1'b0, 8'd34}
  };

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, got, exp);
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] acc, input logic [63:0] res, input logic dz,
                        input int lat, input string name, input bit track);
    exp_t e;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    bus.acc_i   = acc;
    if (track) begin
      e.res = res;
      e.dz  = dz;
      e.cyc = 32'(cyc + lat);
      exp_q.push_back(e);
      name_q.push_back(name);
      last_res = res;
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy_o still 1 after %0d cycles, required 0", n);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.ready_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: ready_o=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        chk({mon_n, "_result"}, bus.result_o, mon_e.res);
        chk({mon_n, "_div0"}, 64'(bus.div0_o), 64'(mon_e.dz));
        chk({mon_n, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    bus.start_i  = 1'b0; bus.op_i  = '0; bus.opa_i  = '0; bus.opb_i  = '0;
    bus.acc_i    = '0;   bus.annul_i  = 1'b0;
    bus2.start_i = 1'b0; bus2.op_i = '0; bus2.opa_i = '0; bus2.opb_i = '0;
    bus2.acc_i   = '0;   bus2.annul_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy_o), 64'd0);
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    chk("reset_div0", 64'(bus.div0_o), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Narrow, 4-bit-per-cycle instance.
    bus2.start_i = 1'b1; bus2.op_i = OP_MULTU; bus2.opa_i = 16'hFFFF; bus2.opb_i = 16'hFFFF;
    c0 = cyc;
    @(negedge clk);
    bus2.start_i = 1'b0;
    for (int n = 0; n < 20 && !bus2.ready_o; n++) @(negedge clk);
    chk("w16_ready", 64'(bus2.ready_o), 64'd1);
    chk("w16_result", 64'(bus2.result_o), 64'h00000000_FFFE0001);
    chk("w16_cycle", 64'(cyc), 64'(c0 + 6));
    @(negedge clk);
    chk("w16_pulse", 64'(bus2.ready_o), 64'd0);

    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, 64'd0, vecs[i].res, vecs[i].dz,
             int'(vecs[i].lat), $sformatf("vec%0d", i), 1'b1);
      if (i == 1) begin
        repeat (3) @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = OP_MULT; bus.opa_i = 32'd1; bus.opb_i = 32'd1;
        @(negedge clk);
        bus.start_i = 1'b0;
      end
      if (i == 10) chk("div0_cleared_at_start", 64'(bus.div0_o), 64'd0);
      wait_idle();
      if (i == 9) chk("div0_held", 64'(bus.div0_o), 64'd1);
    end

`ifdef MULDIV_ACC_EN
    launch(OP_MADD, 32'd4, 32'd5, 64'h10, 64'h24, 1'b0, 34, "madd", 1'b1);
    wait_idle();
    launch(OP_MSUBU, 32'd1, 32'd1, 64'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 34, "msubu", 1'b1);
    wait_idle();
    launch(OP_MSUB, 32'hFFFFFFFE, 32'd3, 64'd100, 64'd106, 1'b0, 34, "msub", 1'b1);
    wait_idle();
`else
    launch(OP_MADD, 32'd4, 32'd5, 64'h10, 64'd0, 1'b0, 0, "madd_illegal", 1'b0);
    chk("illegal_op_busy", 64'(bus.busy_o), 64'd0);
`endif

    bus.annul_i = 1'b1;
    launch(OP_MULT, 32'd2, 32'd2, 64'd0, 64'd0, 1'b0, 0, "annul_start", 1'b0);
    bus.annul_i = 1'b0;
    chk("annul_start_busy", 64'(bus.busy_o), 64'd0);
    repeat (40) @(negedge clk);
    chk("idle_result_held", bus.result_o, last_res);

    // Annul a divide at t+10, then start a multiply right away at t+11.
    launch(OP_DIVU, 32'd1000, 32'd3, 64'd0, 64'd0, 1'b0, 0, "divu_annul", 1'b0);
    repeat (9) @(negedge clk);
    chk("annul_busy_before", 64'(bus.busy_o), 64'd1);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    chk("annul_busy_after", 64'(bus.busy_o), 64'd0);
    chk("annul_result_kept", bus.result_o, last_res);
    launch(OP_MULT, 32'h12345678, 32'h10, 64'd0, 64'h00000001_23456780, 1'b0, 34,
           "mult_after_annul", 1'b1);
    wait_idle();

    launch(OP_DIVU, 32'd1000, 32'd7, 64'd0, 64'd0, 1'b0, 0, "divu_reset", 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", 64'(bus.busy_o), 64'd0);
    chk("async_rst_ready", 64'(bus.ready_o), 64'd0);
    chk("async_rst_result", bus.result_o, 64'd0);
    chk("async_rst_div0", 64'(bus.div0_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    launch(OP_MULT, 32'd3, 32'd3, 64'd0, 64'd9, 1'b0, 34, "mult_after_reset", 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("pending_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
